// File: rtl/spi_master_ctrl_if.sv
// Command/response and SPI pin bundle for spi_master_ctrl.
// slave: the controller itself; master: the requester plus the SPI peer that drives MISO.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport slave (
    input  cmd_valid, cmd, cmd_data, MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );

  modport master (
    output cmd_valid, cmd, cmd_data, MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises one RAM command per handshake into an 11-bit frame
// and, for read-data, captures the returned byte from MISO.
module spi_master_ctrl #(
  parameter int READ_WAIT    = 2,
  parameter int CAPTURE_BITS = 8,
  parameter int IDLE_GAP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_WAIT_RD = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  // The IDLE cycle that precedes an accept also keeps SS_n high, so between
  // frames GAP itself only needs IDLE_GAP-1 cycles to give IDLE_GAP high cycles.
  localparam logic [7:0] GAP_RESET   = 8'(IDLE_GAP);
  localparam logic [7:0] GAP_BETWEEN = 8'(IDLE_GAP - 1);
  localparam bit         GAP_NEEDED  = (IDLE_GAP > 1);
  localparam logic [3:0] WAIT_LOAD   = 4'(READ_WAIT - 1);
  localparam logic [2:0] CAP_LOAD    = 3'(CAPTURE_BITS - 1);

  logic [2:0]  state_q,     state_d;
  logic [10:0] frame_q,     frame_d;
  logic        rd_q,        rd_d;
  logic        tail_q,      tail_d;
  logic [3:0]  bit_cnt_q,   bit_cnt_d;
  logic [3:0]  wait_cnt_q,  wait_cnt_d;
  logic [2:0]  cap_cnt_q,   cap_cnt_d;
  logic [7:0]  sh_q,        sh_d;
  logic [7:0]  gap_cnt_q,   gap_cnt_d;
  logic        ss_n_q,      ss_n_d;
  logic        mosi_q,      mosi_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q,      busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q,  rsp_data_d;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    tail_d      = tail_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    sh_d        = sh_q;
    gap_cnt_d   = gap_cnt_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          frame_d     = {bus.cmd[1], bus.cmd, (bus.cmd == 2'b11) ? 8'h00 : bus.cmd_data};
          rd_d        = (bus.cmd == 2'b11);
          state_d     = ST_SETUP;
          ss_n_d      = 1'b0;
          mosi_d      = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end else begin
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end

      ST_SETUP: begin
        mosi_d    = frame_q[10];
        frame_d   = {frame_q[9:0], 1'b0};
        bit_cnt_d = 4'd10;
        tail_d    = 1'b0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (tail_q) begin
          tail_d = 1'b0;
          ss_n_d = 1'b1;
          if (GAP_NEEDED) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_BETWEEN;
          end else begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
          end
        end else if (bit_cnt_q != 4'd0) begin
          mosi_d    = frame_q[10];
          frame_d   = {frame_q[9:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
        end else if (rd_q) begin
          mosi_d     = 1'b0;
          wait_cnt_d = WAIT_LOAD;
          state_d    = ST_WAIT_RD;
        end else begin
          mosi_d = 1'b0;
          tail_d = 1'b1;
        end
      end

      ST_WAIT_RD: begin
        mosi_d = 1'b0;
        if (wait_cnt_q == 4'd0) begin
          cap_cnt_d = CAP_LOAD;
          state_d   = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        mosi_d = 1'b0;
        sh_d   = {sh_q[6:0], bus.MISO};
        if (cap_cnt_q == 3'd0) begin
          rsp_data_d  = {sh_q[6:0], bus.MISO};
          rsp_valid_d = 1'b1;
          ss_n_d      = 1'b1;
          if (GAP_NEEDED) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_BETWEEN;
          end else begin
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
          end
        end else begin
          cap_cnt_d = cap_cnt_q - 3'd1;
        end
      end

      ST_GAP: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        if (gap_cnt_q <= 8'd1) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d     = ST_GAP;
        gap_cnt_d   = GAP_RESET;
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        cmd_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_GAP;
      frame_q     <= 11'h000;
      rd_q        <= 1'b0;
      tail_q      <= 1'b0;
      bit_cnt_q   <= 4'd0;
      wait_cnt_q  <= 4'd0;
      cap_cnt_q   <= 3'd0;
      sh_q        <= 8'h00;
      gap_cnt_q   <= GAP_RESET;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      tail_q      <= tail_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      sh_q        <= sh_d;
      gap_cnt_q   <= gap_cnt_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a pin-level monitor/MISO model records
// each frame, and directed plus randomised command streams are checked against it.
module tb_spi_master_ctrl;
  localparam int READ_WAIT    = 2;
  localparam int CAPTURE_BITS = 8;
  localparam int IDLE_GAP     = 2;
  localparam int LEN_WR       = 1 + 11 + 1;
  localparam int LEN_RD       = 1 + 11 + READ_WAIT + CAPTURE_BITS;
  localparam int CAP_FIRST    = 1 + 11 + READ_WAIT + 1;
  localparam int CAP_LAST     = CAP_FIRST + CAPTURE_BITS - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(
    .READ_WAIT   (READ_WAIT),
    .CAPTURE_BITS(CAPTURE_BITS),
    .IDLE_GAP    (IDLE_GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [10:0] bits;
    logic        stray;
    int          gap;
    logic [7:0]  miso;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       ss_rise;
  } rsp_t;

  frame_t frames[$];
  rsp_t   rsps[$];
  int     busy_runs[$];

  int total    = 0;
  int bad      = 0;
  int busy_bad = 0;

  logic       force_en   = 1'b0;
  logic [7:0] force_byte = 8'h00;

  int          ss_len    = 0;
  int          hi_len    = 0;
  int          busy_run  = 0;
  int          gap_cur   = 0;
  logic [10:0] bits_cur  = 11'h000;
  logic        stray_cur = 1'b0;
  logic [7:0]  miso_cur  = 8'h00;
  logic        prev_ss   = 1'b1;
  logic [2:0]  bit_sel   = 3'd0;

  // Pin monitor plus slave-side MISO model; MISO carries junk outside the capture window.
  always @(negedge clk) begin
    if (!rst_n) begin
      ss_len   = 0;
      hi_len   = 0;
      busy_run = 0;
      prev_ss  = 1'b1;
      bus.MISO = 1'b0;
    end else begin
      if (!bus.SS_n) begin
        ss_len++;
        if (ss_len == 1) begin
          gap_cur   = hi_len;
          miso_cur  = force_en ? force_byte : 8'($urandom);
          bits_cur  = 11'h000;
          stray_cur = bus.MOSI;
        end else if (ss_len <= 12) begin
          bits_cur = {bits_cur[9:0], bus.MOSI};
        end else begin
          stray_cur = stray_cur | bus.MOSI;
        end
        if (!bus.busy) busy_bad++;
      end else begin
        if (ss_len > 0) begin
          frames.push_back('{ss_len, bits_cur, stray_cur, gap_cur, miso_cur});
          hi_len = 0;
        end
        ss_len = 0;
        hi_len++;
      end
      if (bus.rsp_valid) rsps.push_back('{bus.rsp_data, bus.SS_n & ~prev_ss});
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        busy_runs.push_back(busy_run);
        busy_run = 0;
      end
      if (bus.cmd_ready && bus.busy) busy_bad++;
      prev_ss = bus.SS_n;
      if (ss_len >= CAP_FIRST && ss_len <= CAP_LAST) begin
        bit_sel  = 3'(CAP_LAST - ss_len);
        bus.MISO = miso_cur[bit_sel];
      end else begin
        bus.MISO = 1'($urandom);
      end
    end
  end

  logic [1:0] s_cmd [16];
  logic [7:0] s_dat [16];
  int fr_idx  = 0;
  int rsp_idx = 0;
  int br_idx  = 0;
  int n_reads = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: {cmd[1], cmd, payload}, payload forced to zero for read-data.
  function automatic logic [10:0] exp_bits(input logic [1:0] c, input logic [7:0] d);
    logic [7:0] payload;
    payload = (c == 2'b11) ? 8'h00 : d;
    return {c[1], c, payload};
  endfunction

  // Present s_cmd/s_dat[0..n-1] with cmd_valid held until every one is accepted.
  task automatic stream(input int n);
    int w;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd       = s_cmd[i];
      bus.cmd_data  = s_dat[i];
      w = 0;
      while (!bus.cmd_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      check("accept_timeout", 32'(w < 200), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'($urandom);
  endtask

  task automatic finish_frame(input logic [1:0] c, input logic [7:0] d, input bit b2b);
    int     w;
    frame_t f;
    w = 0;
    while (frames.size() <= fr_idx && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("frame_timeout", 32'(frames.size() > fr_idx), 32'd1);
    if (frames.size() > fr_idx) begin
      f = frames[fr_idx];
      fr_idx++;
      check("frame_bits", 32'(f.bits), 32'(exp_bits(c, d)));
      check("frame_len", 32'(f.len), (c == 2'b11) ? 32'(LEN_RD) : 32'(LEN_WR));
      check("mosi_zero_outside_bits", 32'(f.stray), 32'd0);
      if (b2b) check("gap_len", 32'(f.gap), 32'(IDLE_GAP));
      if (c == 2'b11) begin
        n_reads++;
        last_rd = f.miso;
        check("rsp_present", 32'(rsps.size() > rsp_idx), 32'd1);
        if (rsps.size() > rsp_idx) begin
          check("rsp_data", 32'(rsps[rsp_idx].data), 32'(f.miso));
          check("rsp_with_ss_rise", 32'(rsps[rsp_idx].ss_rise), 32'd1);
          rsp_idx++;
        end
      end
      w = 0;
      while (busy_runs.size() <= br_idx && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("busy_timeout", 32'(busy_runs.size() > br_idx), 32'd1);
      if (busy_runs.size() > br_idx) begin
        check("busy_len", 32'(busy_runs[br_idx]), 32'(f.len + IDLE_GAP - 1));
        br_idx++;
      end
    end
  endtask

  task automatic ready_after_release();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= IDLE_GAP + 1; k++) begin
      @(negedge clk);
      check("ready_after_reset", 32'(bus.cmd_ready), 32'(k >= IDLE_GAP));
    end
  endtask

  initial begin
    int w;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.cmd_data  = 8'h00;

    // Power-on reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", 32'(bus.SS_n), 32'd1);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    ready_after_release();

    // Single write-address with all-ones payload
    s_cmd[0] = 2'b00; s_dat[0] = 8'hFF;
    stream(1);
    finish_frame(2'b00, 8'hFF, 1'b0);

    // Back-to-back write-data then read-address
    s_cmd[0] = 2'b01; s_dat[0] = 8'h0F;
    s_cmd[1] = 2'b10; s_dat[1] = 8'hFF;
    stream(2);
    finish_frame(2'b01, 8'h0F, 1'b0);
    finish_frame(2'b10, 8'hFF, 1'b1);

    // RAM-style sequence: byte 0F stored at FF and read back
    force_en = 1'b1; force_byte = 8'h0F;
    s_cmd[0] = 2'b00; s_dat[0] = 8'hFF;
    s_cmd[1] = 2'b01; s_dat[1] = 8'h0F;
    s_cmd[2] = 2'b10; s_dat[2] = 8'hFF;
    s_cmd[3] = 2'b11; s_dat[3] = 8'h5A;
    stream(4);
    for (int i = 0; i < 4; i++) finish_frame(s_cmd[i], s_dat[i], i > 0);

    // Read-data with fixed MISO pattern 1,0,1,0,0,1,0,1
    force_byte = 8'hA5;
    s_cmd[0] = 2'b11; s_dat[0] = 8'hC3;
    stream(1);
    finish_frame(2'b11, 8'hC3, 1'b0);
    check("rsp_a5_port", 32'(bus.rsp_data), 32'h0000_00A5);
    force_en = 1'b0;

    // Random stream, command type changes every step, ends on a write
    s_cmd[0] = 2'($urandom);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) s_cmd[i] = 2'((32'(s_cmd[i-1]) + 1 + $urandom_range(0, 2)) % 4);
      s_dat[i] = 8'($urandom);
    end
    s_cmd[11] = 2'b01;
    stream(12);
    for (int i = 0; i < 12; i++) finish_frame(s_cmd[i], s_dat[i], i > 0);
    repeat (4) @(negedge clk);
    check("rsp_data_hold", 32'(bus.rsp_data), 32'(last_rd));
    check("frames_no_dup", 32'(frames.size()), 32'(fr_idx));

    // Reset while bit 5 of a write frame is on MOSI
    s_cmd[0] = 2'b00; s_dat[0] = 8'($urandom);
    stream(1);
    w = 0;
    while (ss_len != 7 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("reach_bit5_timeout", 32'(w < 100), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ss_n", 32'(bus.SS_n), 32'd1);
    check("midrst_mosi", 32'(bus.MOSI), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
    repeat (2) @(negedge clk);
    ready_after_release();
    repeat (20) @(negedge clk);
    check("midrst_no_frame", 32'(frames.size()), 32'(fr_idx));

    check("rsp_total", 32'(rsps.size()), 32'(n_reads));
    check("busy_consistency", 32'(busy_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Initiator end of the team's single-clock SPI link; drives SS_n/MOSI and samples MISO of the SPI slave + RAM wrapper.
- Accepts one RAM command per valid/ready handshake: write address, write data, read address or read data.
- Serialises each command into the slave's 11-bit frame.
- For read data, captures the 8 returned bits and presents them on a response port.
- Shares clk with the slave, which uses clk as SCK.

Parameters:
READ_WAIT, 2, cycles after the last MOSI bit of a read-data frame before the first MISO sample (1..15)
CAPTURE_BITS, 8, number of MISO bits captured per read-data frame (fixed 8; parameter exists for bench visibility only)
IDLE_GAP, 2, minimum cycles SS_n stays high between frames (>=1)

Ports:
clk  in  1  system clock, also the SPI bit clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted
cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
cmd_data  in  8  address/data payload; don't-care for 11
rsp_valid  out  1  one-cycle pulse: rsp_data valid
rsp_data  out  8  byte read from slave, MSB first as received
busy  out  1  high from accept until the IDLE_GAP countdown ends
SS_n  out  1  slave select, active low
MOSI  out  1  serial data to slave
MISO  in  1  serial data from slave

Behaviour:
- Reset (async, rst_n low):
  - Outputs: SS_n=1, MOSI=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_data=0.
  - State GAP with the gap counter loaded to IDLE_GAP.
  - Reset mid-frame aborts the frame immediately: SS_n goes high, no response is produced.
- States: IDLE, SETUP, SHIFT, WAIT_RD, CAPTURE, GAP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - Accept occurs on cmd_valid && cmd_ready. On accept, latch frame[10:0] = {cmd[1], cmd, cmd_data}. For cmd 11, cmd_data is replaced by 8'h00.
  - Go to SETUP with SS_n=0 and MOSI=0.
  - cmd_ready drops in the cycle after accept.
- SETUP: exactly one cycle with SS_n low and MOSI=0 (slave IDLE->CHK_CMD). Go to SHIFT.
- SHIFT:
  - Drive frame[10] down to frame[0], one bit per cycle, 11 cycles, 4-bit counter.
  - After bit 0:
    - cmd 11: go to WAIT_RD.
    - otherwise: hold SS_n low for one more cycle, then go to GAP.
- WAIT_RD: MOSI=0 for READ_WAIT cycles, then CAPTURE.
- CAPTURE:
  - Sample MISO on each rising edge for 8 cycles.
  - Shift in: sh = {sh[6:0], MISO}.
  - After the 8th sample: rsp_data = sh, rsp_valid=1 for one cycle, SS_n=1 in the same cycle, go to GAP.
- GAP: SS_n=1, MOSI=0 for IDLE_GAP cycles, then IDLE. busy falls on entry to IDLE.
- Frame lengths, counted from the SS_n falling edge to the first high cycle:
  - Write / read-address: 1+11+1 = 13 cycles.
  - Read-data: 1+11+READ_WAIT+8 = 22 cycles at default.
- Boundary rules:
  - cmd_valid while busy: ignored, no queueing. The requester holds the command until cmd_ready.
  - cmd_valid asserted in the same cycle GAP ends: not accepted until the following IDLE cycle.
  - rsp_valid never asserts for cmd 00/01/10.
  - rsp_data holds its value until the next read-data completes.
  - MISO is ignored outside CAPTURE.
  - Back-to-back commands: SS_n high for exactly IDLE_GAP cycles between frames when cmd_valid is held.

Test Plan:
- Reset mid-SHIFT (rst_n low at bit 5 of a write frame) -> SS_n=1 asynchronously, MOSI=0, no rsp_valid. After release: GAP, then cmd_ready=1 after IDLE_GAP+1 cycles.
- cmd=00, data=8'hFF -> SS_n low 13 cycles. MOSI sequence after the SETUP cycle: 0,0,0,1,1,1,1,1,1,1,1. No rsp_valid.
- cmd=01, data=8'h0F -> MOSI after SETUP: 0,0,1,0,0,0,0,1,1,1,1. Then cmd=10, data=8'hFF -> 1,1,0,1×8. Between frames, SS_n high exactly IDLE_GAP=2 cycles.
- cmd=11 against the SPI slave wrapper holding 8'h0F at addr FF, with READ_WAIT tuned to the slave's turnaround:
  - MOSI after SETUP: 1,1,1,0×8.
  - rsp_valid pulses once, rsp_data=8'h0F.
  - SS_n rises in the same cycle as rsp_valid.
- Behavioural MISO model driving 1,0,1,0,0,1,0,1 starting READ_WAIT cycles after the last MOSI bit -> rsp_data=8'hA5.
- cmd_valid held high continuously with alternating commands -> each accepted only when cmd_ready=1, no command dropped or duplicated, busy high for the whole of each frame plus its gap.
